// File: rtl/saratoga.sv
// Shared interrupt definitions: CSR bit layout, trap cause codes, request FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package saratoga;

    // mip/mie bit layout: standard machine sources plus ten platform lines at 16..25.
    typedef struct packed {
        logic [5:0] rsv_31_26;
        logic [9:0] plat;       // codes 16..25, UART0RX..GPIOC1
        logic [3:0] rsv_15_12;
        logic       meip;       // bit 11
        logic [2:0] rsv_10_8;
        logic       mtip;       // bit 7
        logic [2:0] rsv_6_4;
        logic       msip;       // bit 3
        logic [2:0] rsv_2_0;
    } interrupt_csr_t;

    localparam int IRQ_CODE_WIDTH = 5;
    localparam int IRQ_NUM_SRC    = 13;
    localparam int IRQ_NUM_PLAT   = 10;

    localparam logic [IRQ_CODE_WIDTH-1:0] TRAP_CODE_MSI   = 5'd3;
    localparam logic [IRQ_CODE_WIDTH-1:0] TRAP_CODE_MTI   = 5'd7;
    localparam logic [IRQ_CODE_WIDTH-1:0] TRAP_CODE_MEI   = 5'd11;
    localparam logic [IRQ_CODE_WIDTH-1:0] TRAP_CODE_PLAT0 = 5'd16;

    // Index 0 is the highest priority. MSI deliberately sits above MTI.
    localparam logic [IRQ_CODE_WIDTH-1:0] IRQ_PRIO_ORDER [IRQ_NUM_SRC] = '{
        TRAP_CODE_MEI, TRAP_CODE_MSI, TRAP_CODE_MTI,
        5'd16, 5'd17, 5'd18, 5'd19, 5'd20, 5'd21, 5'd22, 5'd23, 5'd24, 5'd25
    };

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } irq_state_t;

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: eligible interrupt vector -> winning trap cause code.
// Latency: combinational.
// Backpressure: none.
// Ports: eligible (32b in), vld (any winner), code (5b cause of winner).
module irq_prio_enc
    import saratoga::*;
(
    input  logic [31:0]               eligible,
    output logic                      vld,
    output logic [IRQ_CODE_WIDTH-1:0] code
);

    // Walk lowest priority first so the highest-priority hit is the last write.
    always_comb begin
        vld  = 1'b0;
        code = '0;
        for (int k = IRQ_NUM_SRC - 1; k >= 0; k--) begin
            if (eligible[IRQ_PRIO_ORDER[k]]) begin
                vld  = 1'b1;
                code = IRQ_PRIO_ORDER[k];
            end
        end
    end

endmodule

// File: rtl/irq_ctrl.sv
// Machine interrupt controller: edge/level pending, enable gating, priority select, request handshake to core.
// Latency: src_plat edge at clock N -> mip after N -> irq_req after N+1 (+2 with IRQ_CTRL_SYNC_EN).
// Backpressure: request held with stable code until trap_ack; withdrawn if its source stops being eligible.
// Ports: clk, rst (async, active-high); src_plat[9:0] edge lines; src_mei/mti/msi level lines;
//        mie, mstatus_mie, pend_clr, trap_ack from the core; mip, irq_req, irq_code to the core.
// Build option: IRQ_CTRL_SYNC_EN adds a two-flop synchroniser on src_plat.
module irq_ctrl
    import saratoga::*;
#(
    parameter logic [31:0] SRC_MASK = 32'h03FF_0888
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [IRQ_NUM_PLAT-1:0]   src_plat,
    input  logic                      src_mei,
    input  logic                      src_mti,
    input  logic                      src_msi,
    input  logic [31:0]               mie,
    input  logic                      mstatus_mie,
    input  logic [31:0]               pend_clr,
    input  logic                      trap_ack,
    output logic [31:0]               mip,
    output logic                      irq_req,
    output logic [IRQ_CODE_WIDTH-1:0] irq_code
);

    logic [IRQ_NUM_PLAT-1:0] plat_line;

`ifdef IRQ_CTRL_SYNC_EN
    localparam int PRIME_LEN = 3;
    logic [IRQ_NUM_PLAT-1:0] sync1_q, sync2_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= src_plat;
            sync2_q <= sync1_q;
        end
    end
    assign plat_line = sync2_q;
`else
    localparam int PRIME_LEN = 1;
    assign plat_line = src_plat;
`endif

    logic [IRQ_NUM_PLAT-1:0] samp_q;
    logic [IRQ_NUM_PLAT-1:0] pend_q;
    logic [PRIME_LEN-1:0]    prime_q;
    logic [IRQ_NUM_PLAT-1:0] edge_det;
    logic [IRQ_NUM_PLAT-1:0] ack_clr;
    logic [IRQ_NUM_PLAT-1:0] pend_d;
    logic                    ack_take;
    logic                    unused_pend_clr;

    irq_state_t                state_q, state_d;
    logic                      req_d;
    logic [IRQ_CODE_WIDTH-1:0] code_d;
    logic [IRQ_CODE_WIDTH-1:0] enc_code;
    logic                      enc_vld;
    logic [31:0]               eligible;
    interrupt_csr_t            csr_view;

    // prime_q fills with ones after reset release; until the sampler holds a real
    // post-reset sample, a line that was already high must not look like an edge.
    assign edge_det = plat_line & ~samp_q & {IRQ_NUM_PLAT{&prime_q}};

    // trap_ack only counts while a request is actually outstanding.
    assign ack_take = (state_q == REQ) && trap_ack;

    always_comb begin
        ack_clr = '0;
        for (int i = 0; i < IRQ_NUM_PLAT; i++) begin
            ack_clr[i] = ack_take && (irq_code == TRAP_CODE_PLAT0 + IRQ_CODE_WIDTH'(i));
        end
    end

    // A new edge in the same cycle as a clear wins, so no event is lost.
    assign pend_d = (pend_q & ~(pend_clr[25:16] | ack_clr)) | edge_det;

    assign unused_pend_clr = ^{pend_clr[31:26], pend_clr[15:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            samp_q  <= '0;
            pend_q  <= '0;
            prime_q <= '0;
        end else begin
            samp_q  <= plat_line;
            pend_q  <= pend_d;
            prime_q <= (prime_q << 1) | PRIME_LEN'(1);
        end
    end

    always_comb begin
        csr_view      = '0;
        csr_view.plat = pend_q;
        csr_view.meip = src_mei;
        csr_view.mtip = src_mti;
        csr_view.msip = src_msi;
    end

    assign mip      = csr_view & SRC_MASK;
    assign eligible = mip & mie & SRC_MASK & {32{mstatus_mie}};

    irq_prio_enc u_prio_enc (
        .eligible (eligible),
        .vld      (enc_vld),
        .code     (enc_code)
    );

    // Code is latched on entry to REQ and never re-evaluated there: no preemption.
    // HOLD gives the core one cycle to clear mstatus_mie before we look again.
    always_comb begin
        state_d = state_q;
        req_d   = 1'b0;
        code_d  = irq_code;
        unique case (state_q)
            IDLE: begin
                if (enc_vld) begin
                    state_d = REQ;
                    req_d   = 1'b1;
                    code_d  = enc_code;
                end
            end
            REQ: begin
                if (trap_ack) begin
                    state_d = HOLD;
                end else if (!eligible[irq_code]) begin
                    state_d = IDLE;
                end else begin
                    req_d = 1'b1;
                end
            end
            HOLD:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            irq_req  <= 1'b0;
            irq_code <= '0;
        end else begin
            state_q  <= state_d;
            irq_req  <= req_d;
            irq_code <= code_d;
        end
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl with a cycle-level reference model and per-cycle compare.
// Latency: n/a.
// Backpressure: n/a.
module tb_irq_ctrl;

`ifdef IRQ_CTRL_SYNC_EN
    localparam int LAT = 4;   // input change to irq_req, in bench negedges
    localparam int MD  = 2;   // extra delay of platform lines
`else
    localparam int LAT = 2;
    localparam int MD  = 0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [9:0]  src_plat = '0;
    logic        src_mei = 1'b0, src_mti = 1'b0, src_msi = 1'b0;
    logic [31:0] mie = '0;
    logic        mstatus_mie = 1'b0;
    logic [31:0] pend_clr = '0;
    logic        trap_ack = 1'b0;
    logic [31:0] mip;
    logic        irq_req;
    logic [4:0]  irq_code;

    int n_chk = 0;
    int n_bad = 0;

    irq_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .src_plat    (src_plat),
        .src_mei     (src_mei),
        .src_mti     (src_mti),
        .src_msi     (src_msi),
        .mie         (mie),
        .mstatus_mie (mstatus_mie),
        .pend_clr    (pend_clr),
        .trap_ack    (trap_ack),
        .mip         (mip),
        .irq_req     (irq_req),
        .irq_code    (irq_code)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // ---------------- reference model ----------------
    logic [9:0]  m_pend;
    logic [9:0]  hist [0:3];   // hist[k] = src_plat seen k clock edges ago
    int          m_cnt;        // clock edges since reset release
    bit          m_req, m_hold;
    int          m_code;
    logic [31:0] m_el;
    logic [9:0]  m_edges, m_clr;
    int          m_best;

    function automatic logic [31:0] m_mip();
        logic [31:0] v;
        v = {6'b0, m_pend, 16'b0};
        v[11] = src_mei;
        v[7]  = src_mti;
        v[3]  = src_msi;
        return v & 32'h03FF_0888;
    endfunction

    // Smaller rank = more urgent.
    function automatic int rank(input int c);
        if (c == 11) return 0;
        if (c == 3)  return 1;
        if (c == 7)  return 2;
        if (c >= 16 && c <= 25) return c - 13;
        return 99;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_pend = '0;
            m_req  = 0;
            m_hold = 0;
            m_code = 0;
            m_cnt  = 0;
            for (int i = 0; i < 4; i++) hist[i] = '0;
        end else begin
            m_el   = m_mip() & mie & {32{mstatus_mie}};
            m_best = -1;
            for (int c = 0; c < 32; c++)
                if (m_el[c] && (m_best < 0 || rank(c) < rank(m_best))) m_best = c;
            m_clr = pend_clr[25:16];
            if (m_req && trap_ack && m_code >= 16) m_clr[m_code-16] = 1'b1;
            if (m_hold) begin
                m_hold = 0;
            end else if (m_req) begin
                if (trap_ack) begin
                    m_req  = 0;
                    m_hold = 1;
                end else if (!m_el[m_code]) begin
                    m_req = 0;
                end
            end else if (m_best >= 0) begin
                m_req  = 1;
                m_code = m_best;
            end
            for (int i = 3; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = src_plat;
            if (m_cnt < 1000) m_cnt++;
            m_edges = (m_cnt >= MD + 2) ? (hist[MD] & ~hist[MD+1]) : '0;
            m_pend  = (m_pend & ~m_clr) | m_edges;
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(posedge clk);
            #1;
            chk("cyc_mip", mip, m_mip());
            chk("cyc_irq_req", 32'(irq_req), 32'(m_req));
            chk("cyc_irq_code", 32'(irq_code), 32'(m_code));
        end
    end

    // ---------------- directed stimulus ----------------
    initial begin
        #1 rst = 1'b1;
        step(2);
        chk("rst_mip", mip, 32'h0);
        chk("rst_req", 32'(irq_req), 32'h0);
        chk("rst_code", 32'(irq_code), 32'h0);
        rst = 1'b0;
        step(2);

        // Platform edge on line 4 (code 20), ack, HOLD then IDLE.
        mie = 32'h0010_0000;
        mstatus_mie = 1'b1;
        src_plat[4] = 1'b1;
        for (int k = 1; k <= LAT; k++) begin
            step(1);
            chk("t1_mip20", 32'(mip[20]), 32'(k >= LAT - 1));
            chk("t1_req", 32'(irq_req), 32'(k == LAT));
        end
        chk("t1_code", 32'(irq_code), 32'd20);
        chk("t1_model_req", 32'(m_req), 32'h1);
        trap_ack = 1'b1;
        step(1);
        trap_ack = 1'b0;
        chk("t1_mip_after_ack", mip, 32'h0);
        chk("t1_hold_req", 32'(irq_req), 32'h0);
        step(1);
        chk("t1_idle_req", 32'(irq_req), 32'h0);
        src_plat[4] = 1'b0;
        step(2);

        // MSI beats MTI; withdraw when MSI drops, then re-request with MTI.
        mie = 32'h0000_0888;
        src_mti = 1'b1;
        src_msi = 1'b1;
        step(1);
        chk("t2_mip", mip, 32'h0000_0088);
        chk("t2_req", 32'(irq_req), 32'h1);
        chk("t2_code", 32'(irq_code), 32'd3);
        src_msi = 1'b0;
        step(1);
        chk("t2_withdraw", 32'(irq_req), 32'h0);
        step(1);
        chk("t2_rereq", 32'(irq_req), 32'h1);
        chk("t2_code7", 32'(irq_code), 32'd7);
        trap_ack = 1'b1;
        src_mti = 1'b0;
        step(1);
        trap_ack = 1'b0;
        step(2);

        // No preemption: code 16 held while MEI arrives; MEI taken after HOLD.
        mie = 32'h0001_0800;
        src_plat[0] = 1'b1;
        step(LAT);
        chk("t3_req16", 32'(irq_req), 32'h1);
        chk("t3_code16", 32'(irq_code), 32'd16);
        src_mei = 1'b1;
        step(3);
        chk("t3_nopreempt_req", 32'(irq_req), 32'h1);
        chk("t3_nopreempt_code", 32'(irq_code), 32'd16);
        trap_ack = 1'b1;
        step(1);
        trap_ack = 1'b0;
        chk("t3_hold_req", 32'(irq_req), 32'h0);
        chk("t3_mip16_clr", 32'(mip[16]), 32'h0);
        step(1);
        chk("t3_idle_req", 32'(irq_req), 32'h0);
        step(1);
        chk("t3_mei_req", 32'(irq_req), 32'h1);
        chk("t3_mei_code", 32'(irq_code), 32'd11);
        src_mei = 1'b0;
        step(1);
        chk("t3_mei_withdraw", 32'(irq_req), 32'h0);
        src_plat[0] = 1'b0;
        step(2);

        // Clear coincident with new edge; global enable off blocks requests.
        mstatus_mie = 1'b0;
        mie = 32'hFFFF_FFFF;
        src_plat[2] = 1'b1;
        step(LAT - 1);
        chk("t4_mip18_set", 32'(mip[18]), 32'h1);
        src_plat[2] = 1'b0;
        step(1);
        src_plat[2] = 1'b1;
        step(LAT - 2);
        pend_clr[18] = 1'b1;
        step(1);
        pend_clr = '0;
        chk("t4_edge_beats_clr", 32'(mip[18]), 32'h1);
        pend_clr[18] = 1'b1;
        step(1);
        pend_clr = '0;
        chk("t4_clr", 32'(mip[18]), 32'h0);
        src_mei = 1'b1;
        trap_ack = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step(1);
            chk("t4_mip_nonzero", 32'(mip != 0), 32'h1);
            chk("t4_gated_req", 32'(irq_req), 32'h0);
        end
        trap_ack = 1'b0;
        src_mei = 1'b0;
        src_plat = '0;
        mstatus_mie = 1'b1;
        step(2);

        // Reset during REQ; line held high across reset gives no pending.
        mie = 32'h0001_0000;
        src_plat[0] = 1'b1;
        step(LAT);
        chk("t5_req16", 32'(irq_req), 32'h1);
        #2 rst = 1'b1;
        #1;
        chk("t5_rst_req", 32'(irq_req), 32'h0);
        chk("t5_rst_code", 32'(irq_code), 32'h0);
        chk("t5_rst_mip", mip, 32'h0);
        step(1);
        rst = 1'b0;
        step(LAT + 2);
        chk("t5_no_false_edge_mip", mip, 32'h0);
        chk("t5_no_false_edge_req", 32'(irq_req), 32'h0);
        src_plat[0] = 1'b0;
        step(LAT + 1);
        src_plat[0] = 1'b1;
        step(LAT);
        chk("t5_edge_after_rst_req", 32'(irq_req), 32'h1);
        chk("t5_edge_after_rst_code", 32'(irq_code), 32'd16);
        trap_ack = 1'b1;
        step(1);
        trap_ack = 1'b0;
        step(3);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
